// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry result FIFO in front of the register file write port,
// plus the architectural flags register. Optional operand forwarding via WB_FORWARDING_EN.
module alu_writeback_stage #(
    parameter int DataWidth    = 16,
    parameter int RegAddrWidth = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [RegAddrWidth-1:0] InAddr,
    input  logic [DataWidth-1:0]    InData,
    input  logic [4:0]              InFlags,
    input  logic                    InWriteDest,
    input  logic                    InWriteFlags,
    input  logic                    WbReady,
    output logic                    RegWe,
    output logic [RegAddrWidth-1:0] RegAddr,
    output logic [DataWidth-1:0]    RegData,
    output logic [4:0]              Flags,
    input  logic [RegAddrWidth-1:0] QueryAddr,
    output logic                    FwdHit,
    output logic [DataWidth-1:0]    FwdData
);

    // Handshake: a result transfers at a rising edge where InValid && InReady; InReady
    // depends only on occupancy. The register file side retires the head at an edge
    // where a head is present and WbReady is high; WbReady low holds the head.
    logic [RegAddrWidth-1:0] ent_addr  [2];
    logic [DataWidth-1:0]    ent_data  [2];
    logic [4:0]              ent_flags [2];
    logic [1:0]              ent_wd;
    logic [1:0]              ent_wf;

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [4:0] flags_q;

    logic head_valid;
    logic push;
    logic retire;

    assign head_valid = (count != 2'd0);
    assign InReady    = (count != 2'd2);
    assign push       = InValid && InReady && !Reset;
    // Reset wins over retire so nothing reaches the register file while it is held.
    assign retire     = head_valid && WbReady && !Reset;

    always_ff @(posedge Clock) begin
        if (push) begin
            ent_addr[wr_ptr]  <= InAddr;
            ent_data[wr_ptr]  <= InData;
            ent_flags[wr_ptr] <= InFlags;
            ent_wd[wr_ptr]    <= InWriteDest;
            ent_wf[wr_ptr]    <= InWriteFlags;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            flags_q <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (retire) begin
                rd_ptr <= ~rd_ptr;
                if (ent_wf[rd_ptr]) begin
                    flags_q <= ent_flags[rd_ptr];
                end
            end
            // push needs count<2 and retire needs count>0, so this saturates by construction
            case ({push, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign RegWe   = retire && ent_wd[rd_ptr];
    assign RegAddr = head_valid ? ent_addr[rd_ptr] : '0;
    assign RegData = head_valid ? ent_data[rd_ptr] : '0;
    assign Flags   = flags_q;

`ifdef WB_FORWARDING_EN
    // The youngest entry always sits just behind wr_ptr; the older one exists only when full.
    logic young_idx;
    logic old_idx;
    logic hit_young;
    logic hit_old;

    assign young_idx = ~wr_ptr;
    assign old_idx   = wr_ptr;
    assign hit_young = head_valid && ent_wd[young_idx] && (ent_addr[young_idx] == QueryAddr);
    assign hit_old   = (count == 2'd2) && ent_wd[old_idx] && (ent_addr[old_idx] == QueryAddr);

    assign FwdHit  = hit_young || hit_old;
    assign FwdData = hit_young ? ent_data[young_idx] :
                     hit_old   ? ent_data[old_idx]   : '0;
`else
    logic unused_query;
    assign unused_query = ^QueryAddr;
    assign FwdHit       = 1'b0;
    assign FwdData      = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage; forwarding checks follow WB_FORWARDING_EN.
module tb_alu_writeback_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_addr;
    logic [15:0] in_data;
    logic [4:0]  in_flags;
    logic        in_write_dest;
    logic        in_write_flags;
    logic        wb_ready;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [15:0] reg_data;
    logic [4:0]  flags;
    logic [2:0]  query_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard entries are {write_dest, addr, data}
    logic [19:0] exp_q[$];

    alu_writeback_stage #(.DataWidth(16), .RegAddrWidth(3)) dut (
        .Clock(clock), .Reset(reset),
        .InValid(in_valid), .InReady(in_ready), .InAddr(in_addr), .InData(in_data),
        .InFlags(in_flags), .InWriteDest(in_write_dest), .InWriteFlags(in_write_flags),
        .WbReady(wb_ready), .RegWe(reg_we), .RegAddr(reg_addr), .RegData(reg_data),
        .Flags(flags), .QueryAddr(query_addr), .FwdHit(fwd_hit), .FwdData(fwd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [2:0] a, input logic [15:0] d,
                            input logic [4:0] f, input logic wd, input logic wf);
        in_valid       = v;
        in_addr        = a;
        in_data        = d;
        in_flags       = f;
        in_write_dest  = wd;
        in_write_flags = wf;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || reg_we !== 1'b0 || reg_addr !== 3'd0 || reg_data !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%0d data=%h, want 1 0 0 0000",
                     in_ready, reg_we, reg_addr, reg_data);
        end
        n_cmp++;
        if (flags !== 5'd0 || fwd_hit !== 1'b0 || fwd_data !== 16'd0) begin
            n_err++;
            $display("FAIL reset_flags_fwd: flags=%b hit=%b fdata=%h, want 0 0 0", flags, fwd_hit, fwd_data);
        end
    endtask

    task automatic test_single();
        wb_ready = 1'b1;
        drive_in(1'b1, 3'd3, 16'h00A5, 5'd0, 1'b1, 1'b0);
        step();
        drive_in(1'b0, 3'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (reg_we !== 1'b1 || reg_addr !== 3'd3 || reg_data !== 16'h00A5) begin
            n_err++;
            $display("FAIL single_write: we=%b addr=%0d data=%h, want 1 3 00a5", reg_we, reg_addr, reg_data);
        end
        step();
        n_cmp++;
        if (reg_we !== 1'b0 || reg_addr !== 3'd0 || reg_data !== 16'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_empty: we=%b addr=%0d data=%h ready=%b, want 0 0 0000 1",
                     reg_we, reg_addr, reg_data, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic accepted;
        int   n_ret;
        n_ret = 0;
        exp_q.delete();
        wb_ready = 1'b0;
        drive_in(1'b1, 3'd1, 16'h0011, 5'd0, 1'b1, 1'b0);
        step();
        exp_q.push_back({1'b1, 3'd1, 16'h0011});
        drive_in(1'b1, 3'd2, 16'h0022, 5'd0, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_occ1: ready=%b, want 1", in_ready);
        end
        step();
        exp_q.push_back({1'b1, 3'd2, 16'h0022});
        drive_in(1'b1, 3'd3, 16'h0033, 5'd0, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || reg_we !== 1'b0 || reg_addr !== 3'd1 || reg_data !== 16'h0011) begin
            n_err++;
            $display("FAIL b2b_full: ready=%b we=%b addr=%0d data=%h, want 0 0 1 0011",
                     in_ready, reg_we, reg_addr, reg_data);
        end
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || reg_we !== 1'b0 || reg_data !== 16'h0011) begin
            n_err++;
            $display("FAIL b2b_hold: ready=%b we=%b data=%h, want 0 0 0011", in_ready, reg_we, reg_data);
        end
        wb_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            accepted = in_valid && in_ready;
            if (reg_we === 1'b1) begin
                n_ret++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_order: unexpected write addr=%0d data=%h", reg_addr, reg_data);
                end else if ({reg_we, reg_addr, reg_data} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL b2b_order: got %h, want %h", {reg_we, reg_addr, reg_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            step();
            if (accepted) begin
                exp_q.push_back({1'b1, 3'd3, 16'h0033});
                drive_in(1'b0, 3'd0, 16'd0, 5'd0, 1'b0, 1'b0);
            end
            #1;
        end
        n_cmp++;
        if (n_ret != 3 || exp_q.size() != 0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_count: retired=%0d pending=%0d ready=%b, want 3 0 1", n_ret, exp_q.size(), in_ready);
        end
    endtask

    task automatic test_flags();
        wb_ready = 1'b1;
        drive_in(1'b1, 3'd5, 16'h1234, 5'b01001, 1'b0, 1'b1);
        step();
        drive_in(1'b0, 3'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (reg_we !== 1'b0 || reg_addr !== 3'd5 || flags !== 5'd0) begin
            n_err++;
            $display("FAIL flags_before: we=%b addr=%0d flags=%b, want 0 5 00000", reg_we, reg_addr, flags);
        end
        step();
        n_cmp++;
        if (flags !== 5'b01001 || reg_we !== 1'b0) begin
            n_err++;
            $display("FAIL flags_load: flags=%b we=%b, want 01001 0", flags, reg_we);
        end
        // register write without WriteFlags must leave the flags alone
        drive_in(1'b1, 3'd6, 16'h5555, 5'b11111, 1'b1, 1'b0);
        step();
        drive_in(1'b0, 3'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (flags !== 5'b01001) begin
            n_err++;
            $display("FAIL flags_hold: flags=%b, want 01001", flags);
        end
    endtask

    task automatic test_streaming();
        logic [19:0] e;
        exp_q.delete();
        wb_ready = 1'b1;
        drive_in(1'b1, 3'd7, 16'h0100, 5'd0, 1'b1, 1'b0);
        step();
        exp_q.push_back({1'b1, 3'd7, 16'h0100});
        for (int i = 0; i < 8; i++) begin
            e = {(i != 3), 3'(i), 16'h0101 + 16'(i)};
            drive_in(1'b1, e[18:16], e[15:0], 5'd0, e[19], 1'b0);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1 || {reg_we, reg_addr, reg_data} !== exp_q[0]) begin
                n_err++;
                $display("FAIL stream_%0d: ready=%b got %h, want 1 %h", i, in_ready,
                         {reg_we, reg_addr, reg_data}, exp_q[0]);
            end
            void'(exp_q.pop_front());
            step();
            exp_q.push_back(e);
        end
        drive_in(1'b0, 3'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if ({reg_we, reg_addr, reg_data} !== exp_q[0]) begin
            n_err++;
            $display("FAIL stream_last: got %h, want %h", {reg_we, reg_addr, reg_data}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        step();
        n_cmp++;
        if (reg_we !== 1'b0 || reg_addr !== 3'd0 || reg_data !== 16'd0) begin
            n_err++;
            $display("FAIL stream_empty: we=%b addr=%0d data=%h, want 0 0 0000", reg_we, reg_addr, reg_data);
        end
    endtask

    task automatic test_forwarding();
        logic        exp_hit;
        logic [15:0] exp_d7;
        logic [15:0] exp_d9;
`ifdef WB_FORWARDING_EN
        exp_hit = 1'b1;
        exp_d7  = 16'd7;
        exp_d9  = 16'd9;
`else
        exp_hit = 1'b0;
        exp_d7  = 16'd0;
        exp_d9  = 16'd0;
`endif
        wb_ready   = 1'b0;
        query_addr = 3'd2;
        drive_in(1'b1, 3'd2, 16'd7, 5'b11111, 1'b1, 1'b1);
        step();
        drive_in(1'b1, 3'd2, 16'd9, 5'b11111, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (fwd_hit !== exp_hit || fwd_data !== exp_d7) begin
            n_err++;
            $display("FAIL fwd_one: hit=%b data=%h, want %b %h", fwd_hit, fwd_data, exp_hit, exp_d7);
        end
        step();
        drive_in(1'b0, 3'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (fwd_hit !== exp_hit || fwd_data !== exp_d9) begin
            n_err++;
            $display("FAIL fwd_youngest: hit=%b data=%h, want %b %h", fwd_hit, fwd_data, exp_hit, exp_d9);
        end
        query_addr = 3'd4;
        #1;
        n_cmp++;
        if (fwd_hit !== 1'b0 || fwd_data !== 16'd0) begin
            n_err++;
            $display("FAIL fwd_miss: hit=%b data=%h, want 0 0000", fwd_hit, fwd_data);
        end
    endtask

    task automatic test_reset_mid();
        // two entries pending from the forwarding scenario, flags currently 01001
        wb_ready = 1'b1;
        reset    = 1'b1;
        #1;
        n_cmp++;
        if (reg_we !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_during: we=%b, want 0", reg_we);
        end
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (reg_we !== 1'b0 || in_ready !== 1'b1 || flags !== 5'd0 || reg_addr !== 3'd0 || reg_data !== 16'd0) begin
            n_err++;
            $display("FAIL rstmid_after: we=%b ready=%b flags=%b addr=%0d data=%h, want 0 1 00000 0 0000",
                     reg_we, in_ready, flags, reg_addr, reg_data);
        end
        step();
        n_cmp++;
        if (reg_we !== 1'b0 || flags !== 5'd0) begin
            n_err++;
            $display("FAIL rstmid_later: we=%b flags=%b, want 0 00000", reg_we, flags);
        end
    endtask

    initial begin
        reset      = 1'b1;
        wb_ready   = 1'b0;
        query_addr = 3'd0;
        drive_in(1'b0, 3'd0, 16'd0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_flags();
        test_streaming();
        test_forwarding();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
